// File: rtl/scan_misr_reg.sv
// Scannable state register with stuck-at fault injection and a MISR that compacts scan_out.
// Latency: q/qbar, signature, shift_count and shift_done are registered (1 clk); scan_out is combinational from q.
// Backpressure: none; every input is accepted on every rising clk edge.
module scan_misr_reg #(
    parameter int                WIDTH  = 4,
    parameter int                MISR_W = 8,
    parameter logic [MISR_W-1:0] POLY   = 8'h1D
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         d,
    input  logic                     mode,
    input  logic                     scan_in,
    input  logic [WIDTH-1:0]         sa0_mask,
    input  logic [WIDTH-1:0]         sa1_mask,
    input  logic                     misr_en,
    input  logic                     misr_clr,
    output logic [WIDTH-1:0]         q,
    output logic [WIDTH-1:0]         qbar,
    output logic                     scan_out,
    output logic [MISR_W-1:0]        signature,
    output logic [$clog2(WIDTH)-1:0] shift_count,
    output logic                     shift_done
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        FUNC  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [WIDTH-1:0]    fault_dat;
    logic [WIDTH-1:0]    q_nxt;
    logic [MISR_W-1:0]   misr_nxt;
    logic [CW-1:0]       count_base;
    logic [CW-1:0]       count_nxt;
    logic                done_nxt;

    // sa0 overrides sa1 on a bit where both masks are set
    always_comb begin
        fault_dat = (d | sa1_mask) & ~sa0_mask;
        q_nxt     = mode ? {q[WIDTH-2:0], scan_in} : fault_dat;
    end

    assign scan_out = q[WIDTH-1];

    always_comb begin
        misr_nxt = {signature[MISR_W-2:0], 1'b0}
                 ^ (signature[MISR_W-1] ? POLY : '0)
                 ^ {{(MISR_W-1){1'b0}}, scan_out};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= '0;
            qbar <= '1;
        end else begin
            q    <= q_nxt;
            qbar <= ~q_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            signature <= '0;
        end else if (misr_clr) begin
            signature <= '0;
        end else if (misr_en) begin
            signature <= misr_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= FUNC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        if (mode) begin
            state_nxt = SHIFT;
        end else begin
            state_nxt = FUNC;
        end
    end

    // A pass only continues while we stay in SHIFT; entering SHIFT always starts from 0
    always_comb begin
        count_base = (state == SHIFT) ? shift_count : '0;
        count_nxt  = '0;
        done_nxt   = 1'b0;
        if (state_nxt == SHIFT) begin
            if (count_base == LAST) begin
                done_nxt = 1'b1;
            end else begin
                count_nxt = count_base + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_count <= '0;
            shift_done  <= 1'b0;
        end else begin
            shift_count <= count_nxt;
            shift_done  <= done_nxt;
        end
    end

endmodule

// File: tb/tb_scan_misr_reg.sv
// Bench for scan_misr_reg at WIDTH=4, MISR_W=8, POLY=8'h1D: directed scenarios plus a randomized run against a reference model.
module tb_scan_misr_reg;

    localparam logic [7:0] POLY = 8'h1D;

    logic       clk;
    logic       rst;
    logic [3:0] d;
    logic       mode;
    logic       scan_in;
    logic [3:0] sa0_mask;
    logic [3:0] sa1_mask;
    logic       misr_en;
    logic       misr_clr;
    logic [3:0] q;
    logic [3:0] qbar;
    logic       scan_out;
    logic [7:0] signature;
    logic [1:0] shift_count;
    logic       shift_done;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [3:0] mq;
    logic [7:0] msig;
    int         mpass;
    logic       mdone;

    scan_misr_reg #(.WIDTH(4), .MISR_W(8), .POLY(POLY)) dut (
        .clk(clk), .rst(rst), .d(d), .mode(mode), .scan_in(scan_in),
        .sa0_mask(sa0_mask), .sa1_mask(sa1_mask), .misr_en(misr_en),
        .misr_clr(misr_clr), .q(q), .qbar(qbar), .scan_out(scan_out),
        .signature(signature), .shift_count(shift_count), .shift_done(shift_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // signature as a polynomial over GF(2): multiply by x, add the incoming bit, reduce x^8 by POLY
    function automatic logic [7:0] misr_ref(input logic [7:0] s, input logic b);
        int v;
        v = int'(s) * 2 + int'(b);
        if (v >= 256) v = (v - 256) ^ int'(POLY);
        return v[7:0];
    endfunction

    task automatic model_reset();
        mq    = 4'b0000;
        msig  = 8'h00;
        mpass = 0;
        mdone = 1'b0;
    endtask

    // advance the model with the current inputs, then let the DUT take one edge
    task automatic tick();
        logic       sbit;
        logic [3:0] fd;
        sbit = mq[3];
        for (int i = 0; i < 4; i++) begin
            if (sa0_mask[i])      fd[i] = 1'b0;
            else if (sa1_mask[i]) fd[i] = 1'b1;
            else                  fd[i] = d[i];
        end
        if (mode) begin
            mq    = {mq[2:0], scan_in};
            mpass = mpass + 1;
            mdone = (mpass == 4);
            if (mpass == 4) mpass = 0;
        end else begin
            mq    = fd;
            mpass = 0;
            mdone = 1'b0;
        end
        if (misr_clr)     msig = 8'h00;
        else if (misr_en) msig = misr_ref(msig, sbit);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; d = 4'b0000; scan_in = 1'b0;
        sa0_mask = 4'b0000; sa1_mask = 4'b0000; misr_en = 1'b0; misr_clr = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks++; if ({q, qbar} !== 8'h0F) begin errors++; $display("FAIL reset_q_qbar: got %b expected %b", {q, qbar}, 8'h0F); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++; if ({q, qbar, signature, shift_count, shift_done} !== {8'h0F, 8'h00, 2'd0, 1'b0}) begin
            errors++; $display("FAIL reset_release_glitch: got %h expected %h", {q, qbar, signature, shift_count, shift_done}, {8'h0F, 8'h00, 2'd0, 1'b0});
        end
        // get every state element away from its reset value
        @(negedge clk);
        d = 4'b1111; misr_en = 1'b1;
        tick();
        tick();
        mode = 1'b1; scan_in = 1'b1;
        tick();
        checks++; if (signature === 8'h00 || shift_count !== 2'd1) begin
            errors++; $display("FAIL reset_setup: got sig=%h cnt=%0d expected nonzero sig, cnt=1", signature, shift_count);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        checks++; if (q !== 4'b0000)      begin errors++; $display("FAIL async_reset_q: got %b expected 0000", q); end
        checks++; if (qbar !== 4'b1111)   begin errors++; $display("FAIL async_reset_qbar: got %b expected 1111", qbar); end
        checks++; if (signature !== 8'h00) begin errors++; $display("FAIL async_reset_sig: got %h expected 00", signature); end
        checks++; if (shift_count !== 2'd0 || shift_done !== 1'b0) begin
            errors++; $display("FAIL async_reset_cnt_done: got %0d/%b expected 0/0", shift_count, shift_done);
        end
        rst = 1'b1; mode = 1'b0; misr_en = 1'b0; scan_in = 1'b0;
        tick();
    endtask

    task automatic test_func();
        mode = 1'b0; sa0_mask = 4'b0000; sa1_mask = 4'b0000; d = 4'b1010;
        tick();
        checks++; if (q !== 4'b1010)     begin errors++; $display("FAIL func_q: got %b expected 1010", q); end
        checks++; if (qbar !== 4'b0101)  begin errors++; $display("FAIL func_qbar: got %b expected 0101", qbar); end
        checks++; if (scan_out !== 1'b1) begin errors++; $display("FAIL func_scan_out: got %b expected 1", scan_out); end
    endtask

    task automatic test_fault();
        mode = 1'b0; d = 4'b0010; sa0_mask = 4'b0011; sa1_mask = 4'b0101;
        tick();
        checks++; if (q !== 4'b0100) begin errors++; $display("FAIL fault_q: got %b expected 0100", q); end
        checks++; if (qbar !== 4'b1011) begin errors++; $display("FAIL fault_qbar: got %b expected 1011", qbar); end
        sa0_mask = 4'b0000; sa1_mask = 4'b0000;
    endtask

    task automatic test_scan();
        logic       sin[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic       sob[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0] qexp[4] = '{4'b0101, 4'b1011, 4'b0110, 4'b1100};
        logic [1:0] cexp[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic       dexp[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        mode = 1'b0; d = 4'b1010; misr_en = 1'b0; misr_clr = 1'b0;
        tick();
        // masks must not disturb the scan path
        mode = 1'b1; sa0_mask = 4'b1111; sa1_mask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            scan_in = sin[i];
            #1;
            checks++; if (scan_out !== sob[i]) begin errors++; $display("FAIL scan_out_pre%0d: got %b expected %b", i, scan_out, sob[i]); end
            tick();
            checks++; if (q !== qexp[i] || qbar !== ~qexp[i]) begin
                errors++; $display("FAIL scan_q%0d: got %b/%b expected %b/%b", i, q, qbar, qexp[i], ~qexp[i]);
            end
            checks++; if (shift_count !== cexp[i] || shift_done !== dexp[i]) begin
                errors++; $display("FAIL scan_cnt%0d: got %0d/%b expected %0d/%b", i, shift_count, shift_done, cexp[i], dexp[i]);
            end
        end
        mode = 1'b0; sa0_mask = 4'b0000;
        tick();
        checks++; if (shift_done !== 1'b0) begin errors++; $display("FAIL scan_done_single: got %b expected 0", shift_done); end
    endtask

    task automatic test_misr();
        mode = 1'b0; d = 4'b1000; misr_clr = 1'b1; misr_en = 1'b0;
        tick();
        checks++; if (signature !== 8'h00) begin errors++; $display("FAIL misr_clr: got %h expected 00", signature); end
        misr_clr = 1'b0; misr_en = 1'b1; d = 4'b0000;
        tick();
        checks++; if (signature !== 8'h01) begin errors++; $display("FAIL misr_first: got %h expected 01", signature); end
        for (int i = 0; i < 7; i++) tick();
        checks++; if (signature !== 8'h80) begin errors++; $display("FAIL misr_shift: got %h expected 80", signature); end
        d = 4'b1111;
        tick();
        checks++; if (signature !== 8'h1D) begin errors++; $display("FAIL misr_poly: got %h expected 1d", signature); end
        misr_clr = 1'b1;
        tick();
        checks++; if (signature !== 8'h00) begin errors++; $display("FAIL misr_clr_priority: got %h expected 00", signature); end
        misr_clr = 1'b0; misr_en = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        mode = 1'b1;
        for (int i = 0; i < 2; i++) begin
            scan_in = 1'($urandom_range(0, 1));
            tick();
        end
        checks++; if (shift_count !== 2'd2) begin errors++; $display("FAIL midscan_pre: got %0d expected 2", shift_count); end
        rst = 1'b0;
        #1;
        model_reset();
        checks++; if (q !== 4'b0000 || shift_count !== 2'd0) begin
            errors++; $display("FAIL midscan_reset: got q=%b cnt=%0d expected q=0000 cnt=0", q, shift_count);
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            scan_in = 1'($urandom_range(0, 1));
            tick();
            checks++; if (shift_done !== (i == 3) || shift_count !== 2'((i + 1) % 4)) begin
                errors++; $display("FAIL midscan_pass%0d: got done=%b cnt=%0d expected done=%b cnt=%0d", i, shift_done, shift_count, (i == 3), (i + 1) % 4);
            end
        end
        mode = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            mode     = ($urandom_range(0, 9) < 7);
            d        = 4'($urandom);
            scan_in  = 1'($urandom);
            sa0_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            sa1_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            misr_en  = 1'($urandom);
            misr_clr = ($urandom_range(0, 15) == 0);
            tick();
            checks++; if (q !== mq || qbar !== ~mq || scan_out !== mq[3]) begin
                errors++; $display("FAIL rand_q@%0d: got q=%b qbar=%b so=%b expected q=%b", n, q, qbar, scan_out, mq);
            end
            checks++; if (signature !== msig) begin errors++; $display("FAIL rand_sig@%0d: got %h expected %h", n, signature, msig); end
            checks++; if (shift_count !== 2'(mpass) || shift_done !== mdone) begin
                errors++; $display("FAIL rand_cnt@%0d: got %0d/%b expected %0d/%b", n, shift_count, shift_done, mpass, mdone);
            end
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b0;
                #1;
                model_reset();
                checks++; if ({q, qbar, signature, shift_count, shift_done} !== {8'h0F, 8'h00, 2'd0, 1'b0}) begin
                    errors++; $display("FAIL rand_reset@%0d: got %h expected %h", n, {q, qbar, signature, shift_count, shift_done}, {8'h0F, 8'h00, 2'd0, 1'b0});
                end
                rst = 1'b1;
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_func();
        test_fault();
        test_scan();
        test_misr();
        test_reset_mid_scan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
